// File: rtl/ddr_pkg.sv
// Shared types and widths for the step judging pipeline.
// Chart steps are {arrows, timing} pairs; timing counts beat ticks.
package ddr_pkg;

    localparam int ARROW_W  = 4;
    localparam int TIMING_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ACTIVE,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        J_NONE,
        J_HIT,
        J_MISS
    } judge_e;

endpackage : ddr_pkg

// File: rtl/button_edge.sv
// Rising-edge detector for the player buttons: remembers last cycle's
// button levels and flags bits that went from released to pressed.
module button_edge
    import ddr_pkg::*;
#(
    parameter int W_P = ARROW_W
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic [W_P-1:0] buttons_i,
    output logic [W_P-1:0] edge_o
);

    logic [W_P-1:0] buttons_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buttons_q <= '0;
        end else begin
            buttons_q <= buttons_i;
        end
    end

    for (genvar gi = 0; gi < W_P; gi++) begin : g_edge
        assign edge_o[gi] = buttons_i[gi] & ~buttons_q[gi];
    end

endmodule : button_edge

// File: rtl/step_judge.sv
// Holds each chart step for its beat count, judges button presses against
// the step's arrows, and keeps a saturating score and combo.
module step_judge
    import ddr_pkg::*;
#(
    parameter int FETCH_LAT_P = 2,
    parameter int SCORE_W_P   = 16,
    parameter int COMBO_W_P   = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 beat_i,
    input  logic [ARROW_W-1:0]   arrows_i,
    input  logic [TIMING_W-1:0]  timing_i,
    input  logic [ARROW_W-1:0]   buttons_i,
    output logic                 next_o,
    output logic [ARROW_W-1:0]   active_arrows_o,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic [SCORE_W_P-1:0] score_o,
    output logic [COMBO_W_P-1:0] combo_o,
    output logic                 done_o
);

    localparam int FW = $clog2(FETCH_LAT_P + 1);

    state_e                 state_q, state_d;
    logic [FW-1:0]          fetch_cnt_q, fetch_cnt_d;
    logic [TIMING_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [ARROW_W-1:0]     arrows_q, arrows_d;
    logic [TIMING_W-1:0]    timing_q, timing_d;
    logic [ARROW_W-1:0]     acc_q, acc_d;
    logic                   resolved_q, resolved_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic                   next_q, next_d;
    logic [SCORE_W_P-1:0]   score_q, score_d;
    logic [COMBO_W_P-1:0]   combo_q, combo_d;

    logic [ARROW_W-1:0]     edge_w;
    judge_e                 judge;

    button_edge #(
        .W_P (ARROW_W)
    ) u_button_edge (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .buttons_i (buttons_i),
        .edge_o    (edge_w)
    );

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        arrows_d    = arrows_q;
        timing_d    = timing_q;
        acc_d       = acc_q;
        resolved_d  = resolved_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        next_d      = 1'b0;
        score_d     = score_q;
        combo_d     = combo_q;
        judge       = J_NONE;

        // A wrong arrow outranks a chord completed in the same cycle.
        if (state_q == ACTIVE && !resolved_q && arrows_q != '0) begin
            if ((edge_w & ~arrows_q) != '0) begin
                judge = J_MISS;
            end else if ((acc_q | edge_w) == arrows_q) begin
                judge = J_HIT;
            end else begin
                acc_d = acc_q | edge_w;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    score_d     = '0;
                    combo_d     = '0;
                    fetch_cnt_d = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (fetch_cnt_q == FW'(FETCH_LAT_P)) begin
                    arrows_d   = arrows_i;
                    timing_d   = timing_i;
                    beat_cnt_d = '0;
                    acc_d      = '0;
                    resolved_d = 1'b0;
                    state_d    = (timing_i == '0) ? DONE : ACTIVE;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + FW'(1);
                end
            end
            ACTIVE: begin
                if (judge == J_HIT) begin
                    hit_d      = 1'b1;
                    resolved_d = 1'b1;
                    score_d    = (score_q == '1) ? score_q : score_q + SCORE_W_P'(1);
                    combo_d    = (combo_q == '1) ? combo_q : combo_q + COMBO_W_P'(1);
                end else if (judge == J_MISS) begin
                    miss_d     = 1'b1;
                    resolved_d = 1'b1;
                    combo_d    = '0;
                end
                if (beat_i) begin
                    beat_cnt_d = beat_cnt_q + TIMING_W'(1);
                    if (beat_cnt_d == timing_q) begin
                        next_d      = 1'b1;
                        fetch_cnt_d = '0;
                        state_d     = FETCH;
                        if (!resolved_q && arrows_q != '0 && judge == J_NONE) begin
                            miss_d  = 1'b1;
                            combo_d = '0;
                        end
                    end
                end
            end
            DONE: begin
                if (start_i) begin
                    score_d     = '0;
                    combo_d     = '0;
                    next_d      = 1'b1;
                    fetch_cnt_d = '0;
                    state_d     = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            fetch_cnt_q <= '0;
            beat_cnt_q  <= '0;
            arrows_q    <= '0;
            timing_q    <= '0;
            acc_q       <= '0;
            resolved_q  <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            next_q      <= 1'b0;
            score_q     <= '0;
            combo_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            arrows_q    <= arrows_d;
            timing_q    <= timing_d;
            acc_q       <= acc_d;
            resolved_q  <= resolved_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            next_q      <= next_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
        end
    end

    assign next_o          = next_q;
    assign hit_o           = hit_q;
    assign miss_o          = miss_q;
    assign score_o         = score_q;
    assign combo_o         = combo_q;
    assign done_o          = (state_q == DONE);
    assign active_arrows_o = (state_q == ACTIVE) ? arrows_q : '0;

endmodule : step_judge
